// File: rtl/arp_rx_cache.sv
// arp_rx_cache: GMII-side ARP receiver with a small round-robin IP->MAC cache.
// Accepted requests/replies are reported, requests to us raise reply_req, sender bindings are learned.
module arp_rx_cache #(
  parameter logic [47:0] BOARD_MAC    = 48'h12_34_56_78_9a_bc,
  parameter int unsigned CACHE_DEPTH  = 4,
  parameter bit          ACCEPT_REPLY = 1'b1,
  parameter bit          LEARN_ALL    = 1'b0
) (
  input  logic        gmii_rx_clk,
  input  logic        rst,
  input  logic        gmii_rx_dv,
  input  logic [7:0]  gmii_rxd,
  input  logic [31:0] local_ip,
  input  logic        cache_flush,
  output logic        arp_valid,
  output logic        arp_is_req,
  output logic [47:0] arp_src_mac,
  output logic [31:0] arp_src_ip,
  output logic        reply_req,
  input  logic [31:0] lookup_ip,
  output logic        lookup_hit,
  output logic [47:0] lookup_mac,
  output logic [15:0] drop_cnt
);
  localparam int unsigned PW  = (CACHE_DEPTH > 1) ? $clog2(CACHE_DEPTH) : 1;
  localparam int unsigned SRW = 160;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] PREAMBLE = 3'd1;
  localparam logic [2:0] ETH_HEAD = 3'd2;
  localparam logic [2:0] ARP_HEAD = 3'd3;
  localparam logic [2:0] ARP_DATA = 3'd4;
  localparam logic [2:0] COMMIT   = 3'd5;
  localparam logic [2:0] DRAIN    = 3'd6;

  logic [2:0]     state, nxt_state;
  logic [4:0]     cnt, nxt_cnt;
  logic           drop_inc, accept, learn;
  logic [SRW-1:0] sr;
  logic [47:0]    da;
  logic           oper_req;
  logic [63:0]    hdr;
  logic           eth_ok, arp_ok;
  logic [47:0]    sha, tha;
  logic [31:0]    spa, tpa;

  logic [CACHE_DEPTH-1:0] ent_valid;
  logic [31:0]            ent_ip  [CACHE_DEPTH];
  logic [47:0]            ent_mac [CACHE_DEPTH];
  logic [PW-1:0]          ptr, match_idx;
  logic                   match_found, lk_hit_c;
  logic [47:0]            lk_mac_c;

  // Current byte joined with the previous seven: used for the TYPE and ARP header checks.
  assign hdr = {sr[55:0], gmii_rxd};
  assign sha = sr[159:112];
  assign spa = sr[111:80];
  assign tha = sr[79:32];
  assign tpa = sr[31:0];

  assign eth_ok = ((da == 48'hFFFF_FFFF_FFFF) || (da == BOARD_MAC)) && (hdr[15:0] == 16'h0806);
  assign arp_ok = (hdr[63:48] == 16'h0001) && (hdr[47:32] == 16'h0800) &&
                  (hdr[31:24] == 8'h06) && (hdr[23:16] == 8'h04) &&
                  ((hdr[15:0] == 16'h0001) || (ACCEPT_REPLY && (hdr[15:0] == 16'h0002)));
  assign learn  = (state == COMMIT) && (accept || LEARN_ALL) && (spa != 32'h0);

  always_ff @(posedge gmii_rx_clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nxt_state;
      cnt   <= nxt_cnt;
    end
  end

  // Next-state, byte counter, drop and accept decisions.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    drop_inc  = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (gmii_rx_dv) begin
          if (gmii_rxd == 8'h55) begin
            nxt_state = PREAMBLE;
            nxt_cnt   = 5'd1;
          end else begin
            nxt_state = DRAIN;
          end
        end
      end
      PREAMBLE: begin
        if (!gmii_rx_dv) nxt_state = IDLE;
        else if (gmii_rxd == 8'h55) begin
          if (cnt == 5'd7) nxt_state = DRAIN;
          else nxt_cnt = cnt + 5'd1;
        end else if (gmii_rxd == 8'hD5) begin
          nxt_state = ETH_HEAD;
          nxt_cnt   = '0;
        end else nxt_state = DRAIN;
      end
      ETH_HEAD: begin
        if (!gmii_rx_dv) begin
          nxt_state = IDLE;
          drop_inc  = 1'b1;
        end else if (cnt == 5'd13) begin
          nxt_cnt = '0;
          if (eth_ok) nxt_state = ARP_HEAD;
          else begin
            nxt_state = DRAIN;
            drop_inc  = 1'b1;
          end
        end else nxt_cnt = cnt + 5'd1;
      end
      ARP_HEAD: begin
        if (!gmii_rx_dv) begin
          nxt_state = IDLE;
          drop_inc  = 1'b1;
        end else if (cnt == 5'd7) begin
          nxt_cnt = '0;
          if (arp_ok) nxt_state = ARP_DATA;
          else begin
            nxt_state = DRAIN;
            drop_inc  = 1'b1;
          end
        end else nxt_cnt = cnt + 5'd1;
      end
      ARP_DATA: begin
        if (!gmii_rx_dv) begin
          nxt_state = IDLE;
          drop_inc  = 1'b1;
        end else if (cnt == 5'd19) begin
          nxt_state = COMMIT;
          nxt_cnt   = '0;
        end else nxt_cnt = cnt + 5'd1;
      end
      COMMIT: begin
        accept    = (tpa == local_ip) && (oper_req || (tha == BOARD_MAC));
        drop_inc  = !accept;
        nxt_state = DRAIN;
      end
      DRAIN: begin
        if (!gmii_rx_dv) nxt_state = IDLE;
      end
      default: nxt_state = IDLE;
    endcase
  end

  // Cache search for learning (by SPA) and for the lookup port; lowest index wins.
  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    lk_hit_c    = 1'b0;
    lk_mac_c    = '0;
    for (int unsigned i = 0; i < CACHE_DEPTH; i++) begin
      if (!match_found && ent_valid[i] && (ent_ip[i] == spa)) begin
        match_found = 1'b1;
        match_idx   = PW'(i);
      end
      if (!lk_hit_c && ent_valid[i] && (ent_ip[i] == lookup_ip)) begin
        lk_hit_c = 1'b1;
        lk_mac_c = ent_mac[i];
      end
    end
  end

  always_ff @(posedge gmii_rx_clk or posedge rst) begin
    if (rst) begin
      sr          <= '0;
      da          <= '0;
      oper_req    <= 1'b0;
      arp_valid   <= 1'b0;
      arp_is_req  <= 1'b0;
      arp_src_mac <= '0;
      arp_src_ip  <= '0;
      reply_req   <= 1'b0;
      lookup_hit  <= 1'b0;
      lookup_mac  <= '0;
      drop_cnt    <= '0;
      ent_valid   <= '0;
      ptr         <= '0;
      for (int unsigned i = 0; i < CACHE_DEPTH; i++) begin
        ent_ip[i]  <= '0;
        ent_mac[i] <= '0;
      end
    end else begin
      arp_valid  <= 1'b0;
      reply_req  <= 1'b0;
      lookup_hit <= lk_hit_c;
      lookup_mac <= lk_mac_c;
      if (gmii_rx_dv && ((state == ETH_HEAD) || (state == ARP_HEAD) || (state == ARP_DATA)))
        sr <= {sr[SRW-9:0], gmii_rxd};
      if (gmii_rx_dv && (state == ETH_HEAD) && (cnt < 5'd6))
        da <= {da[39:0], gmii_rxd};
      if (gmii_rx_dv && (state == ARP_HEAD) && (cnt == 5'd7))
        oper_req <= (hdr[15:0] == 16'h0001);
      if (accept) begin
        arp_valid   <= 1'b1;
        arp_is_req  <= oper_req;
        arp_src_mac <= sha;
        arp_src_ip  <= spa;
        reply_req   <= oper_req;
      end
      if (drop_inc) drop_cnt <= drop_cnt + 16'd1;
      // Flush beats a coincident learn.
      if (cache_flush) begin
        ent_valid <= '0;
        ptr       <= '0;
      end else if (learn) begin
        if (match_found) ent_mac[match_idx] <= sha;
        else begin
          ent_ip[ptr]    <= spa;
          ent_mac[ptr]   <= sha;
          ent_valid[ptr] <= 1'b1;
          ptr            <= (ptr == PW'(CACHE_DEPTH - 1)) ? '0 : ptr + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_arp_rx_cache.sv
// tb_arp_rx_cache: directed ARP frames against two receivers (replies accepted / refused).
// Expected values are hand-computed from the frame contents.
module tb_arp_rx_cache;
  localparam logic [47:0] BMAC = 48'h12_34_56_78_9a_bc;
  localparam logic [47:0] BCST = 48'hFFFF_FFFF_FFFF;
  localparam logic [31:0] LIP  = 32'hC0A8_0001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        gmii_rx_dv = 1'b0;
  logic [7:0]  gmii_rxd = 8'h00;
  logic [31:0] local_ip = LIP;
  logic        cache_flush = 1'b0;
  logic [31:0] lookup_ip = 32'h0;

  logic        arp_valid, arp_is_req, reply_req, lookup_hit;
  logic [47:0] arp_src_mac, lookup_mac;
  logic [31:0] arp_src_ip;
  logic [15:0] drop_cnt;
  logic        arp_valid1, arp_is_req1, reply_req1, lookup_hit1;
  logic [47:0] arp_src_mac1, lookup_mac1;
  logic [31:0] arp_src_ip1;
  logic [15:0] drop_cnt1;

  int checks = 0;
  int errors = 0;

  always #4 clk = ~clk;

  arp_rx_cache dut (
    .gmii_rx_clk(clk), .rst(rst), .gmii_rx_dv(gmii_rx_dv), .gmii_rxd(gmii_rxd),
    .local_ip(local_ip), .cache_flush(cache_flush), .arp_valid(arp_valid),
    .arp_is_req(arp_is_req), .arp_src_mac(arp_src_mac), .arp_src_ip(arp_src_ip),
    .reply_req(reply_req), .lookup_ip(lookup_ip), .lookup_hit(lookup_hit),
    .lookup_mac(lookup_mac), .drop_cnt(drop_cnt)
  );

  arp_rx_cache #(.ACCEPT_REPLY(1'b0)) dut_noreply (
    .gmii_rx_clk(clk), .rst(rst), .gmii_rx_dv(gmii_rx_dv), .gmii_rxd(gmii_rxd),
    .local_ip(local_ip), .cache_flush(cache_flush), .arp_valid(arp_valid1),
    .arp_is_req(arp_is_req1), .arp_src_mac(arp_src_mac1), .arp_src_ip(arp_src_ip1),
    .reply_req(reply_req1), .lookup_ip(lookup_ip), .lookup_hit(lookup_hit1),
    .lookup_mac(lookup_mac1), .drop_cnt(drop_cnt1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    gmii_rx_dv = 1'b1;
    gmii_rxd   = b;
    tick();
  endtask

  task automatic preamble();
    for (int i = 0; i < 7; i++) send_byte(8'h55);
    send_byte(8'hD5);
  endtask

  function automatic logic [335:0] mk(input logic [47:0] da, input logic [15:0] oper,
                                      input logic [47:0] sha, input logic [31:0] spa,
                                      input logic [47:0] tha, input logic [31:0] tpa);
    return {da, 48'h0200_0000_00EE, 16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04,
            oper, sha, spa, tha, tpa};
  endfunction

  task automatic send_range(input logic [335:0] f, input int from, input int to);
    for (int i = from; i <= to; i++) send_byte(f[8*(41-i) +: 8]);
  endtask

  // Full frame; returns with the receiver in its commit cycle.
  task automatic run_frame(input logic [335:0] f);
    preamble();
    send_range(f, 0, 41);
  endtask

  task automatic end_frame();
    gmii_rx_dv = 1'b0;
    gmii_rxd   = 8'h00;
    tick();
  endtask

  task automatic req(input logic [31:0] spa, input logic [47:0] sha);
    run_frame(mk(BCST, 16'h0001, sha, spa, 48'h0, LIP));
    end_frame();
    tick();
  endtask

  task automatic look(input string tag, input logic [31:0] ip, input logic hit, input logic [47:0] mac);
    lookup_ip = ip;
    tick();
    chk({tag, "_hit"}, 64'(lookup_hit), 64'(hit));
    chk({tag, "_mac"}, 64'(lookup_mac), 64'(mac));
  endtask

  initial begin
    tick();
    tick();
    chk("rst_valid", 64'(arp_valid), 64'(1'b0));
    chk("rst_drop", 64'(drop_cnt), 64'(16'h0));
    chk("rst_mac", 64'(arp_src_mac), 64'(48'h0));
    chk("rst_hit", 64'(lookup_hit), 64'(1'b0));
    rst = 1'b0;
    tick();

    // Broadcast request to us
    run_frame(mk(BCST, 16'h0001, 48'h2cf05d32f107, 32'hC0A8_0002, 48'h0, LIP));
    chk("lat_early", 64'(arp_valid), 64'(1'b0));
    end_frame();
    chk("req_valid", 64'(arp_valid), 64'(1'b1));
    chk("req_reply", 64'(reply_req), 64'(1'b1));
    chk("req_isreq", 64'(arp_is_req), 64'(1'b1));
    chk("req_sha", 64'(arp_src_mac), 64'(48'h2cf05d32f107));
    chk("req_spa", 64'(arp_src_ip), 64'(32'hC0A8_0002));
    lookup_ip = 32'hC0A8_0002;
    tick();
    chk("req_pulse", 64'(arp_valid), 64'(1'b0));
    chk("req_lk_hit", 64'(lookup_hit), 64'(1'b1));
    chk("req_lk_mac", 64'(lookup_mac), 64'(48'h2cf05d32f107));

    // Request for another IP: dropped, nothing learned
    run_frame(mk(BCST, 16'h0001, 48'h2cf05d32f1aa, 32'hC0A8_0003, 48'h0, 32'hC0A8_0009));
    end_frame();
    chk("other_valid", 64'(arp_valid), 64'(1'b0));
    chk("other_reply", 64'(reply_req), 64'(1'b0));
    chk("other_drop", 64'(drop_cnt), 64'(16'd1));
    chk("other_held", 64'(arp_src_ip), 64'(32'hC0A8_0002));
    look("other_lk", 32'hC0A8_0003, 1'b0, 48'h0);

    // Unicast reply: accepted only where replies are enabled
    run_frame(mk(BMAC, 16'h0002, 48'h0200_0000_0005, 32'hC0A8_0005, BMAC, LIP));
    end_frame();
    chk("rep_valid", 64'(arp_valid), 64'(1'b1));
    chk("rep_isreq", 64'(arp_is_req), 64'(1'b0));
    chk("rep_reply", 64'(reply_req), 64'(1'b0));
    chk("rep_drop", 64'(drop_cnt), 64'(16'd1));
    chk("norep_valid", 64'(arp_valid1), 64'(1'b0));
    chk("norep_drop", 64'(drop_cnt1), 64'(16'd2));
    tick();

    // Round-robin eviction: 02,05,10,11,12 learned into 4 entries
    req(32'hC0A8_0010, 48'h0200_0000_0010);
    req(32'hC0A8_0011, 48'h0200_0000_0011);
    req(32'hC0A8_0012, 48'h0200_0000_0012);
    look("ev_02", 32'hC0A8_0002, 1'b0, 48'h0);
    look("ev_05", 32'hC0A8_0005, 1'b1, 48'h0200_0000_0005);
    look("ev_10", 32'hC0A8_0010, 1'b1, 48'h0200_0000_0010);
    look("ev_12", 32'hC0A8_0012, 1'b1, 48'h0200_0000_0012);

    // In-place update keeps the pointer: next new entry evicts 05, not 10
    req(32'hC0A8_0010, 48'h0600_0000_0010);
    look("upd_10", 32'hC0A8_0010, 1'b1, 48'h0600_0000_0010);
    req(32'hC0A8_0013, 48'h0200_0000_0013);
    look("ptr_05", 32'hC0A8_0005, 1'b0, 48'h0);
    look("ptr_10", 32'hC0A8_0010, 1'b1, 48'h0600_0000_0010);
    look("ptr_11", 32'hC0A8_0011, 1'b1, 48'h0200_0000_0011);
    look("ptr_13", 32'hC0A8_0013, 1'b1, 48'h0200_0000_0013);
    chk("ptr_drop", 64'(drop_cnt), 64'(16'd1));

    // dv lost at ARP_DATA byte 12
    preamble();
    send_range(mk(BCST, 16'h0001, 48'h0200_0000_0014, 32'hC0A8_0014, 48'h0, LIP), 0, 32);
    end_frame();
    chk("abort_drop", 64'(drop_cnt), 64'(16'd2));
    tick();
    chk("abort_valid", 64'(arp_valid), 64'(1'b0));
    look("abort_lk", 32'hC0A8_0014, 1'b0, 48'h0);
    run_frame(mk(BCST, 16'h0001, 48'h0200_0000_0014, 32'hC0A8_0014, 48'h0, LIP));
    end_frame();
    chk("after_valid", 64'(arp_valid), 64'(1'b1));
    chk("after_spa", 64'(arp_src_ip), 64'(32'hC0A8_0014));
    tick();

    // Reset in the middle of ARP_DATA
    preamble();
    send_range(mk(BCST, 16'h0001, 48'h0200_0000_0015, 32'hC0A8_0015, 48'h0, LIP), 0, 29);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_mac", 64'(arp_src_mac), 64'(48'h0));
    chk("mrst_ip", 64'(arp_src_ip), 64'(32'h0));
    chk("mrst_drop", 64'(drop_cnt), 64'(16'h0));
    chk("mrst_lkmac", 64'(lookup_mac), 64'(48'h0));
    send_range(mk(BCST, 16'h0001, 48'h0200_0000_0015, 32'hC0A8_0015, 48'h0, LIP), 30, 41);
    end_frame();
    chk("mrst_valid", 64'(arp_valid), 64'(1'b0));
    tick();
    chk("mrst_drop2", 64'(drop_cnt), 64'(16'h0));
    look("mrst_lk", 32'hC0A8_0013, 1'b0, 48'h0);

    // Flush coincident with a learning commit
    run_frame(mk(BCST, 16'h0001, 48'h0200_0000_0020, 32'hC0A8_0020, 48'h0, LIP));
    cache_flush = 1'b1;
    end_frame();
    cache_flush = 1'b0;
    chk("fl_valid", 64'(arp_valid), 64'(1'b1));
    look("fl_lk", 32'hC0A8_0020, 1'b0, 48'h0);
    req(32'hC0A8_0021, 48'h0200_0000_0021);
    look("fl_relearn", 32'hC0A8_0021, 1'b1, 48'h0200_0000_0021);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
